// File: rtl/control_flow_tracker_if.sv
`default_nettype none
// ============================================================================
// control_flow_tracker_if : redirect request / holdoff qualifier bundle
// Revision: 1.0
// ============================================================================
interface control_flow_tracker_if #(
  parameter int XLEN = 32
);
  logic            i_stall;
  logic            i_trap_taken;
  logic [XLEN-1:0] i_trap_target;
  logic            i_mret_taken;
  logic [XLEN-1:0] i_mret_target;
  logic            i_branch_taken;
  logic [XLEN-1:0] i_branch_target;
  logic            i_prediction_taken;
  logic [XLEN-1:0] i_prediction_target;
  logic            i_spanning_to_halfword;
  logic            o_redirect_valid;
  logic [XLEN-1:0] o_redirect_pc;
  logic [1:0]      o_redirect_cause;
  logic            o_flush;
  logic            o_control_flow_holdoff;
  logic            o_prediction_holdoff;
  logic            o_any_holdoff_safe;

  modport slave (
    input  i_stall, i_trap_taken, i_trap_target, i_mret_taken, i_mret_target,
           i_branch_taken, i_branch_target, i_prediction_taken,
           i_prediction_target, i_spanning_to_halfword,
    output o_redirect_valid, o_redirect_pc, o_redirect_cause, o_flush,
           o_control_flow_holdoff, o_prediction_holdoff, o_any_holdoff_safe
  );

  modport master (
    output i_stall, i_trap_taken, i_trap_target, i_mret_taken, i_mret_target,
           i_branch_taken, i_branch_target, i_prediction_taken,
           i_prediction_target, i_spanning_to_halfword,
    input  o_redirect_valid, o_redirect_pc, o_redirect_cause, o_flush,
           o_control_flow_holdoff, o_prediction_holdoff, o_any_holdoff_safe
  );
endinterface
`default_nettype wire

// File: rtl/control_flow_tracker.sv
`default_nettype none
// ============================================================================
// control_flow_tracker : redirect arbitration, flush window, holdoff flops
// Revision: 1.0
// ============================================================================
module control_flow_tracker #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  wire logic               i_clk,
  input  wire logic               i_reset,
  control_flow_tracker_if.slave   bus
);
  localparam logic [2:0] C_FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [1:0] C_CAUSE_PRED = 2'b00;
  localparam logic [1:0] C_CAUSE_BR   = 2'b01;
  localparam logic [1:0] C_CAUSE_MRET = 2'b10;
  localparam logic [1:0] C_CAUSE_TRAP = 2'b11;

  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       cf_holdoff_q, cf_holdoff_d;
  logic       pred_holdoff_q, pred_holdoff_d;
  logic       span_holdoff_q, span_holdoff_d;

  logic w_flush;
  logic w_trap_acc, w_mret_acc, w_br_acc, w_pred_acc, w_cf_acc;

  assign w_flush    = (flush_cnt_q != 3'd0);
  assign w_trap_acc = bus.i_trap_taken;
  assign w_mret_acc = bus.i_mret_taken & ~bus.i_trap_taken;
  assign w_br_acc   = bus.i_branch_taken & ~bus.i_stall & ~bus.i_trap_taken & ~bus.i_mret_taken;
  assign w_cf_acc   = w_trap_acc | w_mret_acc | w_br_acc;
  // A stalled branch still blocks a same-cycle prediction: it is present, just not accepted.
  assign w_pred_acc = bus.i_prediction_taken & ~bus.i_stall & ~w_flush & ~cf_holdoff_q &
                      ~bus.i_trap_taken & ~bus.i_mret_taken & ~bus.i_branch_taken;

  always_comb begin
    bus.o_redirect_valid = w_cf_acc | w_pred_acc;
    bus.o_redirect_pc    = '0;
    bus.o_redirect_cause = C_CAUSE_PRED;
    if (w_trap_acc) begin
      bus.o_redirect_pc    = bus.i_trap_target;
      bus.o_redirect_cause = C_CAUSE_TRAP;
    end else if (w_mret_acc) begin
      bus.o_redirect_pc    = bus.i_mret_target;
      bus.o_redirect_cause = C_CAUSE_MRET;
    end else if (w_br_acc) begin
      bus.o_redirect_pc    = bus.i_branch_target;
      bus.o_redirect_cause = C_CAUSE_BR;
    end else if (w_pred_acc) begin
      bus.o_redirect_pc    = bus.i_prediction_target;
      bus.o_redirect_cause = C_CAUSE_PRED;
    end
  end

  always_comb begin
    flush_cnt_d    = flush_cnt_q;
    cf_holdoff_d   = cf_holdoff_q;
    pred_holdoff_d = pred_holdoff_q;
    span_holdoff_d = span_holdoff_q;
    if (w_cf_acc) begin
      flush_cnt_d    = C_FLUSH_LOAD;
      cf_holdoff_d   = 1'b1;
      pred_holdoff_d = 1'b0;
      span_holdoff_d = 1'b0;
    end else if (!bus.i_stall) begin
      if (w_flush) flush_cnt_d = flush_cnt_q - 3'd1;
      cf_holdoff_d   = 1'b0;
      pred_holdoff_d = w_pred_acc;
      span_holdoff_d = bus.i_spanning_to_halfword;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      flush_cnt_q    <= 3'd0;
      cf_holdoff_q   <= 1'b0;
      pred_holdoff_q <= 1'b0;
      span_holdoff_q <= 1'b0;
    end else begin
      flush_cnt_q    <= flush_cnt_d;
      cf_holdoff_q   <= cf_holdoff_d;
      pred_holdoff_q <= pred_holdoff_d;
      span_holdoff_q <= span_holdoff_d;
    end
  end

  assign bus.o_flush                = w_flush;
  assign bus.o_control_flow_holdoff = cf_holdoff_q;
  assign bus.o_prediction_holdoff   = pred_holdoff_q;
  assign bus.o_any_holdoff_safe     = cf_holdoff_q | pred_holdoff_q | span_holdoff_q;
endmodule
`default_nettype wire
